// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace monitor: state encoding and width helpers.
package pipe_trace_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StPost  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // One trace entry holds {valid, pc} for every stage.
  function automatic int unsigned entry_w(input int unsigned num_stages,
                                          input int unsigned data_w);
    return num_stages * (data_w + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one extra bit to represent a completely full buffer.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read with a cleared output.
module trace_ram
  import pipe_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 85,
  localparam int unsigned AW   = ptr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its value between pops so rd_data stays stable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pipe_trace_monitor.sv
// Pipeline trace and performance monitor with arm/trigger/post-trigger capture.
// Optional build macro TRACE_STALL_FILTER_EN: stalled cycles are not captured.
module pipe_trace_monitor
  import pipe_trace_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned ENTRY_W   = entry_w(NUM_STAGES, DATA_W),
  localparam int unsigned AW        = ptr_w(DEPTH),
  localparam int unsigned CW        = cnt_w(DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_STAGES-1:0]        stage_valid_i,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_pc_i,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic                         arm_i,
  input  logic                         trig_i,
  input  logic [CW-1:0]                post_trig_i,
  input  logic                         rd_en_i,
  output logic [ENTRY_W-1:0]           rd_data_o,
  output logic                         rd_valid_o,
  output logic [1:0]                   state_o,
  output logic [CW-1:0]                count_o,
  output logic [CNT_W-1:0]             total_cycles_o,
  output logic [CNT_W-1:0]             stall_cycles_o,
  output logic [CNT_W-1:0]             flush_cycles_o
);

  localparam logic [CW-1:0] MaxRem = CW'(DEPTH - 1);
  localparam logic [CW-1:0] Full   = CW'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0] total_q, stall_q, flush_q;
  logic             rd_valid_q;

  logic             qual_gate, capture, we, pop;
  logic [CW-1:0]    trig_rem;
  logic [AW-1:0]    rd_addr;
  logic [ENTRY_W-1:0] wdata;

`ifdef TRACE_STALL_FILTER_EN
  assign qual_gate = ~stall_i;
`else
  assign qual_gate = 1'b1;
`endif

  assign capture  = ((state_q == StArmed) || (state_q == StPost)) && qual_gate;
  assign we       = capture && !arm_i;
  assign pop      = (state_q == StDone) && rd_en_i && (count_q != '0) && !arm_i;
  // Power-of-two depth makes the pointer subtraction wrap modulo DEPTH.
  assign rd_addr  = wr_ptr_q - count_q[AW-1:0];
  assign trig_rem = (post_trig_i > MaxRem) ? MaxRem : post_trig_i;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      wdata[i*(DATA_W+1) +: DATA_W+1] = {stage_valid_i[i], stage_pc_i[i*DATA_W +: DATA_W]};
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rem_d    = rem_q;
    if (arm_i) begin
      state_d  = StArmed;
      wr_ptr_d = '0;
      count_d  = '0;
      rem_d    = '0;
    end else begin
      if (we) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (count_q != Full) begin
          count_d = count_q + CW'(1);
        end
      end
      if (pop) begin
        count_d = count_q - CW'(1);
      end
      case (state_q)
        StArmed: begin
          if (trig_i) begin
            rem_d   = trig_rem;
            state_d = (trig_rem == '0) ? StDone : StPost;
          end
        end
        StPost: begin
          if (capture) begin
            rem_d = rem_q - CW'(1);
            if (rem_q == CW'(1)) begin
              state_d = StDone;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rem_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      rd_valid_q <= pop;
    end
  end

  // Performance counters run in every state and stick at all-ones.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      total_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (total_q != '1) total_q <= total_q + CNT_W'(1);
      if (stall_i && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_i && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_trace_ram (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .re_i    (pop),
    .raddr_i (rd_addr),
    .rdata_o (rd_data_o)
  );

  assign rd_valid_o     = rd_valid_q;
  assign state_o        = state_q;
  assign count_o        = count_q;
  assign total_cycles_o = total_q;
  assign stall_cycles_o = stall_q;
  assign flush_cycles_o = flush_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Directed self-checking bench for pipe_trace_monitor; a narrow-counter twin checks saturation.
module tb_pipe_trace_monitor;

  localparam int NS = 5;
  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int CW = 5;
  localparam int EW = NS * (DW + 1);
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, stall, flush, arm, trig, rd_en;
  logic [NS-1:0]     stage_valid;
  logic [NS*DW-1:0]  stage_pc;
  logic [CW-1:0]     post_trig;
  logic [EW-1:0]     rd_data, sat_rd_data;
  logic              rd_valid, sat_rd_valid;
  logic [1:0]        state, sat_state;
  logic [CW-1:0]     count, sat_count;
  logic [31:0]       total_cycles, stall_cycles, flush_cycles;
  logic [SW-1:0]     sat_total, sat_stall, sat_flush;

  int errors = 0;
  int checks = 0;

  pipe_trace_monitor #(.NUM_STAGES(NS), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk_i(clk), .reset_i(reset), .stage_valid_i(stage_valid), .stage_pc_i(stage_pc),
    .stall_i(stall), .flush_i(flush), .arm_i(arm), .trig_i(trig), .post_trig_i(post_trig),
    .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid), .state_o(state),
    .count_o(count), .total_cycles_o(total_cycles), .stall_cycles_o(stall_cycles),
    .flush_cycles_o(flush_cycles)
  );

  pipe_trace_monitor #(.NUM_STAGES(NS), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(SW)) u_sat (
    .clk_i(clk), .reset_i(reset), .stage_valid_i(stage_valid), .stage_pc_i(stage_pc),
    .stall_i(stall), .flush_i(flush), .arm_i(arm), .trig_i(trig), .post_trig_i(post_trig),
    .rd_en_i(rd_en), .rd_data_o(sat_rd_data), .rd_valid_o(sat_rd_valid), .state_o(sat_state),
    .count_o(sat_count), .total_cycles_o(sat_total), .stall_cycles_o(sat_stall),
    .flush_cycles_o(sat_flush)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Stage i carries pc k + 256*i; valid bits follow the low bits of k.
  task automatic set_stage(input int k);
    stage_valid = NS'(k);
    for (int i = 0; i < NS; i++) stage_pc[i*DW +: DW] = DW'(k + 256 * i);
  endtask

  function automatic logic [EW-1:0] exp_entry(input int k);
    logic [EW-1:0] e;
    logic [NS-1:0] v;
    v = NS'(k);
    e = '0;
    for (int i = 0; i < NS; i++) e[i*(DW+1) +: DW+1] = {v[i], DW'(k + 256 * i)};
    return e;
  endfunction

  task automatic do_arm;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic test_trace_post4;
    post_trig = 5'd4;
    do_arm();
    checks++;
    if (state !== 2'd1) begin
      errors++; $display("FAIL post4_armed: state=%0d expected 1", state);
    end
    for (int k = 1; k <= 24; k++) begin
      set_stage(k);
      trig = (k == 20);
      step();
      if (k == 20 || k == 23) begin
        checks++;
        if (state !== 2'd2) begin
          errors++; $display("FAIL post4_post k=%0d: state=%0d expected 2", k, state);
        end
      end
    end
    trig = 1'b0;
    checks++;
    if (state !== 2'd3 || count !== 5'd16) begin
      errors++; $display("FAIL post4_done: state=%0d count=%0d expected 3/16", state, count);
    end
    for (int j = 0; j < 16; j++) begin
      rd_en = 1'b1;
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_entry(9 + j) || count !== 5'(15 - j)) begin
        errors++;
        $display("FAIL post4_pop%0d: valid=%b data=%h count=%0d expected 1/%h/%0d",
                 j, rd_valid, rd_data, count, exp_entry(9 + j), 15 - j);
      end
    end
    rd_en = 1'b0;
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL post4_idle_valid: rd_valid=%b expected 0", rd_valid);
    end
  endtask

  task automatic test_reset;
    do_arm();
    stall = 1'b1;
    flush = 1'b1;
    set_stage(7);
    repeat (3) step();
    stall = 1'b0;
    flush = 1'b0;
    do_reset(3);
    checks++;
    if (state !== 2'd0 || count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_state: state=%0d count=%0d rd_valid=%b rd_data=%h expected 0",
               state, count, rd_valid, rd_data);
    end
    checks++;
    if (total_cycles !== 32'd0 || stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: total=%0d stall=%0d flush=%0d expected 0",
               total_cycles, stall_cycles, flush_cycles);
    end
    step();
    checks++;
    if (state !== 2'd0 || rd_valid !== 1'b0 || total_cycles !== 32'd1) begin
      errors++;
      $display("FAIL reset_after: state=%0d rd_valid=%b total=%0d expected 0/0/1",
               state, rd_valid, total_cycles);
    end
  endtask

  task automatic test_post_zero;
    post_trig = 5'd0;
    do_arm();
    for (int k = 1; k <= 3; k++) begin
      set_stage(k);
      trig = (k == 3);
      step();
    end
    trig = 1'b0;
    checks++;
    if (state !== 2'd3 || count !== 5'd3) begin
      errors++; $display("FAIL post0_done: state=%0d count=%0d expected 3/3", state, count);
    end
    for (int j = 1; j <= 3; j++) begin
      rd_en = 1'b1;
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_entry(j)) begin
        errors++;
        $display("FAIL post0_pop%0d: valid=%b data=%h expected 1/%h", j, rd_valid, rd_data,
                 exp_entry(j));
      end
    end
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0) begin
      errors++; $display("FAIL post0_empty_pop: valid=%b count=%0d expected 0/0", rd_valid, count);
    end
  endtask

  task automatic test_clamp;
    post_trig = 5'd31;
    do_arm();
    for (int k = 1; k <= 18; k++) begin
      set_stage(k);
      trig = (k == 3);
      step();
      if (k == 17) begin
        checks++;
        if (state !== 2'd2) begin
          errors++; $display("FAIL clamp_post: state=%0d expected 2", state);
        end
      end
    end
    trig = 1'b0;
    checks++;
    if (state !== 2'd3 || count !== 5'd16) begin
      errors++; $display("FAIL clamp_done: state=%0d count=%0d expected 3/16", state, count);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_entry(3)) begin
      errors++;
      $display("FAIL clamp_oldest: valid=%b data=%h expected 1/%h", rd_valid, rd_data,
               exp_entry(3));
    end
  endtask

  task automatic test_stall_filter;
    logic [31:0] t0, s0, f0;
    int exp_count;
`ifdef TRACE_STALL_FILTER_EN
    exp_count = 5;
`else
    exp_count = 10;
`endif
    t0 = total_cycles;
    s0 = stall_cycles;
    f0 = flush_cycles;
    do_arm();
    for (int c = 0; c < 10; c++) begin
      set_stage(c + 40);
      stall = (c % 2 == 1);
      flush = (c < 3);
      step();
    end
    stall = 1'b0;
    flush = 1'b0;
    checks++;
    if (stall_cycles - s0 !== 32'd5 || flush_cycles - f0 !== 32'd3 || total_cycles - t0 !== 32'd11)
    begin
      errors++;
      $display("FAIL stall_counters: stall=%0d flush=%0d total=%0d expected 5/3/11",
               stall_cycles - s0, flush_cycles - f0, total_cycles - t0);
    end
    checks++;
    if (count !== 5'(exp_count) || state !== 2'd1) begin
      errors++;
      $display("FAIL stall_count: count=%0d state=%0d expected %0d/1", count, state, exp_count);
    end
  endtask

  task automatic test_arm_trig;
    do_reset(2);
    arm = 1'b1;
    trig = 1'b1;
    step();
    arm = 1'b0;
    trig = 1'b0;
    checks++;
    if (state !== 2'd1 || count !== 5'd0) begin
      errors++; $display("FAIL arm_trig: state=%0d count=%0d expected 1/0", state, count);
    end
    step();
    checks++;
    if (state !== 2'd1) begin
      errors++; $display("FAIL arm_trig_hold: state=%0d expected 1", state);
    end
  endtask

  task automatic test_saturation;
    do_reset(1);
    stall = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 6 || c == 7 || c == 9) begin
        checks++;
        if (sat_stall !== SW'(c > 7 ? 7 : c) || sat_total !== SW'(c > 7 ? 7 : c)) begin
          errors++;
          $display("FAIL sat_c%0d: stall=%0d total=%0d expected %0d", c, sat_stall, sat_total,
                   c > 7 ? 7 : c);
        end
      end
    end
    stall = 1'b0;
    checks++;
    if (stall_cycles !== 32'd9 || sat_flush !== 3'd0) begin
      errors++;
      $display("FAIL sat_wide: stall=%0d flush_narrow=%0d expected 9/0", stall_cycles, sat_flush);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; arm = 1'b0; trig = 1'b0; rd_en = 1'b0;
    post_trig = '0; stage_valid = '0; stage_pc = '0;
    do_reset(2);
    test_trace_post4();
    test_reset();
    test_post_zero();
    test_clamp();
    test_stall_filter();
    test_arm_trig();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_trace_monitor.md
Name: pipe_trace_monitor

Overview:
- Synthesizable on-chip trace and performance monitor for the pipelined CPU; generalises the bench-only stage display and cycle count into a parametrised block.
- Samples per-stage valid/PC of an N-stage pipeline into a circular trace buffer, with arm/trigger/post-trigger capture.
- Keeps saturating cycle, stall and flush counters.
- Sits beside the core; frozen trace is read out through a pop handshake.

Parameters:
NUM_STAGES, 5, number of pipeline stages traced (stage 0 = IF)
DATA_W, 16, per-stage PC/instruction word width
DEPTH, 16, trace entries; power of two, >=4
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  reset
stage_valid  in  NUM_STAGES  per-stage valid, bit i = stage i
stage_pc  in  NUM_STAGES*DATA_W  packed stage words, stage 0 at LSBs
stall  in  1  pipeline stall this cycle
flush  in  1  pipeline flush this cycle
arm  in  1  pulse: clear buffer, start capture
trig  in  1  trigger event
post_trig  in  $clog2(DEPTH)+1  samples kept after trigger sample
rd_en  in  1  pop oldest entry
rd_data  out  NUM_STAGES*(DATA_W+1)  {valid,pc} per stage, stage 0 at LSBs
rd_valid  out  1  rd_data valid
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
count  out  $clog2(DEPTH)+1  entries held
total_cycles, stall_cycles, flush_cycles  out  CNT_W  counters

Behaviour:
- Reset is synchronous, active-high: state=IDLE; count, wr_ptr, counters, rd_data, rd_valid all 0. Reset mid-capture or mid-readout discards everything.
- Counters run in every state:
  - total_cycles +1 per non-reset cycle.
  - stall_cycles +1 when stall=1.
  - flush_cycles +1 when flush=1.
  - All saturate at all-ones.
- Sample: {stage_valid, stage_pc} of the current cycle, written at wr_ptr. wr_ptr wraps modulo DEPTH. count saturates at DEPTH; when full, the oldest entry is overwritten.
- Capture qualifies in ARMED and POST on every cycle, subject to the optional feature.
- IDLE --arm--> ARMED. The arm cycle itself is not captured. count and wr_ptr clear.
- ARMED --trig--> POST:
  - The trigger-cycle sample is written if it qualifies.
  - remaining = min(post_trig, DEPTH-1) is latched, so the trigger sample always survives.
  - If remaining=0, go directly to DONE after that cycle.
- POST: each qualifying write decrements remaining; when it reaches 0, the next state is DONE. trig is ignored.
- DONE: buffer frozen, no writes.
  - rd_en with count>0 reads entry (wr_ptr-count) mod DEPTH and decrements count.
  - rd_data/rd_valid appear the next cycle (1-cycle latency). rd_valid is high one cycle per accepted pop.
  - rd_en with count=0, or in any other state, is ignored; rd_valid=0.
- arm in any state restarts at ARMED with the buffer cleared. A pending read data beat still completes.
- arm and trig in the same cycle: arm wins, trig dropped.
- trig in IDLE or DONE: ignored.

Optional Feature:
- Macro TRACE_STALL_FILTER_EN.
- Defined: cycles with stall=1 do not qualify for capture and do not decrement remaining, so the trace holds only advancing cycles.
- Undefined: every ARMED/POST cycle is captured regardless of stall.
- Counters are unaffected either way.

Decomposition:
- Package pipe_trace_pkg holds:
  - the state enum (IDLE/ARMED/POST/DONE);
  - an ENTRY_W function, NUM_STAGES*(DATA_W+1);
  - pointer-width helper constants.
- One natural sub-module: trace_ram, a simple dual-port DEPTH x ENTRY_W memory with synchronous write and registered read. The FSM, pointers and counters live in the top.

Test Plan:
- Reset for 3 cycles mid-ARMED -> state=0, count=0, all counters 0, rd_valid=0 the cycle after reset drops.
- DEPTH=16, post_trig=4, stall=0: arm, then stage_pc[0]=k on the k-th armed cycle, trig at k=20 -> DONE after k=24. 16 pops return k=9..24 in order; count goes 16->0; rd_valid 1 cycle after each rd_en.
- post_trig=0, trig at k=3 -> DONE next cycle; count=3; pops return 1,2,3; a 4th rd_en gives rd_valid=0.
- post_trig=31 with DEPTH=16 -> clamped to 15; the trigger sample is the oldest of 16 entries.
- stall high on 5 of 10 armed cycles -> stall_cycles=5. With TRACE_STALL_FILTER_EN, count=5; without it, count=10.
- arm and trig asserted together from IDLE -> state=ARMED, not POST. Counters preset near all-ones saturate and do not wrap.
